fpu_resp_buffer: RTL and testbench



---
 rtl/fpu_resp_buffer_if.sv | 42 ++++
 rtl/fpu_resp_buffer.sv | 131 +++++++++++++
 tb/tb_fpu_resp_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_resp_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_resp_buffer_if
// Description : Response-path bundle between the FPU response tree / request
//               arbiter (master side) and fpu_resp_buffer (slave side).
//               Signals keep the direction suffixes as seen from the buffer.
// Ports       : data_r_valid_i/rdata_i/flag_i  tree response (no back-pressure)
//               issue_i                         request granted, reserves a slot
//               credit_avail_o                  a slot is free for a new issue
//               data_r_valid_o/rdata_o/flag_o   buffered head response
//               data_r_ready_i                  core accepts head response
//               err_o                           sticky protocol-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_resp_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 8
);
  logic                  data_r_valid_i;
  logic [DATA_WIDTH-1:0] data_r_rdata_i;
  logic [FLAG_WIDTH-1:0] data_r_flag_i;
  logic                  issue_i;
  logic                  credit_avail_o;
  logic                  data_r_valid_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  logic [FLAG_WIDTH-1:0] data_r_flag_o;
  logic                  data_r_ready_i;
  logic                  err_o;

  // Buffer side
  modport slave (
    input  data_r_valid_i, data_r_rdata_i, data_r_flag_i, issue_i, data_r_ready_i,
    output credit_avail_o, data_r_valid_o, data_r_rdata_o, data_r_flag_o, err_o
  );

  // Tree / core side
  modport master (
    output data_r_valid_i, data_r_rdata_i, data_r_flag_i, issue_i, data_r_ready_i,
    input  credit_avail_o, data_r_valid_o, data_r_rdata_o, data_r_flag_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/fpu_resp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_resp_buffer
// Description : Credit-managed FIFO between the non-stallable FPU response
//               tree and the core response port. Every response is stored and
//               released under valid/ready. An outstanding counter (reserved
//               in-flight ops plus stored entries) gates new issues so a slot
//               is always available. Violations set a sticky error.
// Ports       : clk    clock
//               rst_n  asynchronous active-low reset
//               bus    fpu_resp_buffer_if.slave (see interface header)
// Parameters  : DATA_WIDTH result width, FLAG_WIDTH flag width,
//               DEPTH entries (power of two, >= 2)
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_resp_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  fpu_resp_buffer_if.slave bus
);

  localparam int C_PTR_W   = $clog2(DEPTH);
  localparam int C_CNT_W   = $clog2(DEPTH + 1);
  localparam int C_ENTRY_W = DATA_WIDTH + FLAG_WIDTH;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_ZERO  = '0;

  // Storage and bookkeeping registers
  logic [C_ENTRY_W-1:0] r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_CNT_W-1:0]   r_count;
  logic [C_CNT_W-1:0]   r_out_cnt;
  logic                 r_err;

  logic                 w_full;
  logic                 w_credit;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue_ok;
  logic                 w_issue_err;
  logic                 w_drop;
  logic                 w_unreserved;
  logic                 w_out_dec;
  logic [C_CNT_W-1:0]   w_count_nxt;
  logic [C_CNT_W-1:0]   w_out_nxt;
  logic [C_ENTRY_W-1:0] w_head;

  assign w_full   = (r_count == C_DEPTH);
  assign w_credit = (r_out_cnt < C_DEPTH);
  assign w_valid  = (r_count != C_ZERO);
  assign w_pop    = w_valid && bus.data_r_ready_i;

  // A pop frees a slot in the same cycle, so a full buffer still accepts
  // a push (and an issue) when the head leaves.
  assign w_push      = bus.data_r_valid_i && (!w_full || w_pop);
  assign w_drop      = bus.data_r_valid_i && w_full && !w_pop;
  assign w_issue_ok  = bus.issue_i && (w_credit || w_pop);
  assign w_issue_err = bus.issue_i && !w_credit && !w_pop;

  // out_cnt == count means every counted op is already stored, i.e. no
  // reservation is in flight. An issue accepted in the same cycle is treated
  // as the reservation backing this push.
  assign w_unreserved = bus.data_r_valid_i && (r_out_cnt == r_count) && !w_issue_ok;

  // Saturating decrement: an unreserved (erroneous) entry was never counted,
  // so its pop must not wrap the counter below zero.
  assign w_out_dec = w_pop && (r_out_cnt != C_ZERO);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - C_ONE;
    end
  end

  always_comb begin
    w_out_nxt = r_out_cnt;
    if (w_issue_ok && !w_out_dec) begin
      w_out_nxt = r_out_cnt + C_ONE;
    end else if (w_out_dec && !w_issue_ok) begin
      w_out_nxt = r_out_cnt - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        // DEPTH is a power of two, so the natural pointer overflow wraps
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      r_count   <= w_count_nxt;
      r_out_cnt <= w_out_nxt;
      r_err     <= r_err || w_issue_err || w_drop || w_unreserved;
    end
  end

  // Data array carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.data_r_rdata_i, bus.data_r_flag_i};
    end
  end

  // Outputs come from registers only; head is gated to zero when empty.
  assign w_head             = w_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.data_r_valid_o = w_valid;
  assign bus.data_r_rdata_o = w_head[C_ENTRY_W-1:FLAG_WIDTH];
  assign bus.data_r_flag_o  = w_head[FLAG_WIDTH-1:0];
  assign bus.credit_avail_o = w_credit;
  assign bus.err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_resp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_resp_buffer
// Description : Self-checking bench for fpu_resp_buffer. A reference model
//               tracks reserved ops, stored entries and the sticky error; the
//               expected response stream lives in a queue consumed by an
//               independent monitor whenever the DUT completes a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_resp_buffer;

  localparam int DW    = 32;
  localparam int FW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [FW-1:0] f;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_resp_buffer_if #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW)) bus ();

  fpu_resp_buffer #(
    .DATA_WIDTH (DW),
    .FLAG_WIDTH (FW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Reference model state
  int m_res;      // issued ops whose response has not arrived yet
  int m_stored;   // responses sitting in the buffer
  bit m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every completed handshake must deliver the oldest expected response
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && bus.data_r_valid_o === 1'b1 && bus.data_r_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: actual data=%0h required none at %0t",
                 bus.data_r_rdata_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("head_data", 64'(bus.data_r_rdata_o), 64'(mon_e.d));
        chk("head_flag", 64'(bus.data_r_flag_o), 64'(mon_e.f));
      end
    end
  end

  task automatic model_clear();
    m_res    = 0;
    m_stored = 0;
    m_err    = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs after the edge, check the visible state at
  // the falling edge, then advance the model by what the next edge will do.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [FW-1:0] f,
                      input logic iss, input logic rdy);
    bit pop, issue_ok;
    @(posedge clk);
    #1;
    bus.data_r_valid_i = v;
    bus.data_r_rdata_i = d;
    bus.data_r_flag_i  = f;
    bus.issue_i        = iss;
    bus.data_r_ready_i = rdy;
    @(negedge clk);
    chk("valid_o", 64'(bus.data_r_valid_o), 64'(m_stored > 0));
    chk("credit_o", 64'(bus.credit_avail_o), 64'((m_res + m_stored) < DEPTH));
    chk("err_o", 64'(bus.err_o), 64'(m_err));
    if (m_stored == 0) begin
      chk("empty_rdata", 64'(bus.data_r_rdata_o), 64'd0);
      chk("empty_flag", 64'(bus.data_r_flag_o), 64'd0);
    end
    pop      = (m_stored > 0) && rdy;
    issue_ok = iss && (((m_res + m_stored) < DEPTH) || pop);
    if (iss && !issue_ok) m_err = 1;
    if (issue_ok) m_res++;
    if (v) begin
      if (m_res > 0) m_res--;
      else m_err = 1;
      if (m_stored < DEPTH || pop) begin
        exp_q.push_back('{d: d, f: f});
        m_stored++;
      end else begin
        m_err = 1;
      end
    end
    if (pop) m_stored--;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.data_r_valid_i = 1'b0;
    bus.data_r_rdata_i = '0;
    bus.data_r_flag_i  = '0;
    bus.issue_i        = 1'b0;
    bus.data_r_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    chk("rst_valid", 64'(bus.data_r_valid_o), 64'd0);
    chk("rst_rdata", 64'(bus.data_r_rdata_o), 64'd0);
    chk("rst_credit", 64'(bus.credit_avail_o), 64'd1);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_stored > 0; i++) idle(1'b1);
    if (m_stored > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual stored=%0d required 0", m_stored);
    end
    idle(1'b0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pushed;
    logic iss, v, rdy;

    // Single op: issue, response three cycles later, pop
    do_reset();
    idle(1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b1, 32'hDEADBEEF, 8'h01, 1'b0, 1'b0);
    drain();

    // Fill credits, over-issue, then fill and drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);     // no credit: ignored, error
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), FW'(i), 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // Full buffer with simultaneous push, pop and issue
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), FW'(i), 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 32'd5, 8'd5, 1'b1, 1'b1);
    idle(1'b0);
    drain();

    // Overflow drop: full, no pop, unreserved push
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'h10 + i), FW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hAA, 8'hAA, 1'b0, 1'b0);
    idle(1'b0);
    drain();

    // Pointer wrap: ten values with ready toggling
    do_reset();
    pushed = 0;
    for (int k = 0; k < 60 && pushed < 10; k++) begin
      rdy = (k % 2 == 0);
      iss = ((m_res + m_stored) < DEPTH);
      step(iss, DW'(100 + pushed), FW'(pushed), iss, rdy);
      if (iss) pushed++;
    end
    drain();

    // Randomized legal traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rdy = 1'($urandom_range(0, 1));
      iss = ($urandom_range(0, 1) == 1) &&
            (((m_res + m_stored) < DEPTH) || (rdy && m_stored > 0));
      v   = ($urandom_range(0, 2) != 0) && (m_res > 0);
      step(v, DW'($urandom), FW'($urandom), iss, rdy);
    end
    for (int i = 0; i < 40 && m_res > 0; i++) step(1'b1, DW'($urandom), FW'($urandom), 1'b0, 1'b0);
    drain();

    // Asynchronous reset with three entries stored
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h55 + i), FW'(i), 1'b1, 1'b0);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(bus.data_r_valid_o), 64'd0);
    chk("async_rdata", 64'(bus.data_r_rdata_o), 64'd0);
    chk("async_flag", 64'(bus.data_r_flag_o), 64'd0);
    chk("async_credit", 64'(bus.credit_avail_o), 64'd1);
    chk("async_err", 64'(bus.err_o), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
